luma_frame_stats: RTL

- Downstream consumer of the brightness/contrast stage's RGB565 video stream.
- Computes per-pixel luma, then per-frame statistics: sum, pixel count, min, max and mean (mean via a sequential divider).
- Passes the video through with a fixed 2-cycle delay.
- Stats feed the auto-exposure control/OSD logic, which steps the brightness/contrast settings.

---
 rtl/luma_frame_stats.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/luma_frame_stats.sv
// luma_frame_stats
//   Computes BT.601-style luma from an RGB565 stream, then gathers per-frame
//   statistics (sum, pixel count, min, max, mean) and passes the video through
//   with a fixed two-cycle delay. The mean is produced by a sequential
//   restoring divider once the frame closes.
//
// Ports
//   img_720_clk_i : pixel clock, the only clock
//   rst           : synchronous active-high reset
//   vin_vs/hs/de  : input syncs and data enable
//   vin_data      : RGB565 pixel {R[15:11], G[10:5], B[4:0]}
//   vout_*        : inputs delayed by exactly two cycles, unmodified
//   stat_valid    : one-cycle pulse, stat_* updated in this cycle
//   stat_sum/cnt  : luma sum and pixel count of the last complete frame
//   stat_min/max  : luma extremes of that frame
//   stat_mean     : floor(stat_sum / stat_cnt)
//   busy          : divider iterating

module luma_frame_stats #(
    parameter logic        VS_POL = 1'b1,
    parameter int unsigned CNT_W  = 21,
    parameter int unsigned SUM_W  = 29
) (
    input  logic             img_720_clk_i,
    input  logic             rst,
    input  logic             vin_vs,
    input  logic             vin_hs,
    input  logic             vin_de,
    input  logic [15:0]      vin_data,
    output logic             vout_vs,
    output logic             vout_hs,
    output logic             vout_de,
    output logic [15:0]      vout_data,
    output logic             stat_valid,
    output logic [SUM_W-1:0] stat_sum,
    output logic [CNT_W-1:0] stat_cnt,
    output logic [7:0]       stat_min,
    output logic [7:0]       stat_max,
    output logic [7:0]       stat_mean,
    output logic             busy
);

    localparam int unsigned IW = $clog2(SUM_W);
    localparam logic [IW-1:0] ITER_LAST = IW'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Luma pipeline and video delay line
    // ------------------------------------------------------------------
    logic [7:0]  r8, g8, b8;
    logic [15:0] p_d;

    logic        vs_d1_q, hs_d1_q, de_d1_q;
    logic [15:0] data_d1_q;
    logic [15:0] p_q;
    logic        vs_d2_q, hs_d2_q, de_d2_q;
    logic [15:0] data_d2_q;
    logic [7:0]  y_q;

    always_comb begin
        r8  = {vin_data[15:11], vin_data[15:13]};
        g8  = {vin_data[10:5],  vin_data[10:9]};
        b8  = {vin_data[4:0],   vin_data[4:2]};
        // Coefficients sum to 256, so the weighted sum never exceeds 16 bits.
        p_d = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    end

    always_ff @(posedge img_720_clk_i) begin
        if (rst) begin
            vs_d1_q   <= 1'b0;
            hs_d1_q   <= 1'b0;
            de_d1_q   <= 1'b0;
            data_d1_q <= '0;
            p_q       <= '0;
            vs_d2_q   <= 1'b0;
            hs_d2_q   <= 1'b0;
            de_d2_q   <= 1'b0;
            data_d2_q <= '0;
            y_q       <= '0;
        end else begin
            vs_d1_q   <= vin_vs;
            hs_d1_q   <= vin_hs;
            de_d1_q   <= vin_de;
            data_d1_q <= vin_data;
            p_q       <= p_d;
            vs_d2_q   <= vs_d1_q;
            hs_d2_q   <= hs_d1_q;
            de_d2_q   <= de_d1_q;
            data_d2_q <= data_d1_q;
            y_q       <= 8'(p_q >> 8);
        end
    end

    assign vout_vs   = vs_d2_q;
    assign vout_hs   = hs_d2_q;
    assign vout_de   = de_d2_q;
    assign vout_data = data_d2_q;

    // Frame end: the registered vsync has just entered its active level.
    logic frame_end;
    assign frame_end = (vs_d1_q == VS_POL) && (vs_d2_q != VS_POL);

    // ------------------------------------------------------------------
    // Running accumulators
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] run_sum_q, run_sum_d, base_sum;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, base_cnt;
    logic [7:0]       run_min_q, run_min_d, base_min;
    logic [7:0]       run_max_q, run_max_d, base_max;
    logic [SUM_W:0]   sum_ext;
    logic             armed_q;

    // On a frame end the accumulators restart, and a pixel arriving in that
    // same cycle is the first pixel of the new frame.
    always_comb begin
        base_sum  = frame_end ? '0    : run_sum_q;
        base_cnt  = frame_end ? '0    : run_cnt_q;
        base_min  = frame_end ? 8'hFF : run_min_q;
        base_max  = frame_end ? 8'h00 : run_max_q;
        sum_ext   = {1'b0, base_sum} + {{(SUM_W - 7){1'b0}}, y_q};
        run_sum_d = base_sum;
        run_cnt_d = base_cnt;
        run_min_d = base_min;
        run_max_d = base_max;
        if (de_d2_q) begin
            run_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            run_cnt_d = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
            run_min_d = (y_q < base_min) ? y_q : base_min;
            run_max_d = (y_q > base_max) ? y_q : base_max;
        end
    end

    always_ff @(posedge img_720_clk_i) begin
        if (rst) begin
            run_sum_q <= '0;
            run_cnt_q <= '0;
            run_min_q <= 8'hFF;
            run_max_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            run_sum_q <= run_sum_d;
            run_cnt_q <= run_cnt_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            if (frame_end) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Snapshot and restoring divider
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [SUM_W-1:0] snap_sum_q;
    logic [CNT_W-1:0] snap_cnt_q;
    logic [7:0]       snap_min_q, snap_max_q;
    logic [SUM_W-1:0] quo_q;
    logic [CNT_W-1:0] rem_q;
    logic [IW-1:0]    iter_q;
    logic             busy_q;
    logic             stat_valid_q;
    logic [SUM_W-1:0] stat_sum_q;
    logic [CNT_W-1:0] stat_cnt_q;
    logic [7:0]       stat_min_q, stat_max_q, stat_mean_q;

    logic             start;
    logic [CNT_W:0]   rem_shift;
    logic             div_ge;
    logic [CNT_W-1:0] rem_sub;

    // A frame end while the divider is occupied drops that frame's snapshot.
    assign start = frame_end && armed_q && (state_q == S_IDLE);

    // quo_q starts as the dividend and shifts quotient bits in from the LSB.
    assign rem_shift = {rem_q, quo_q[SUM_W-1]};
    assign div_ge    = rem_shift >= {1'b0, snap_cnt_q};
    assign rem_sub   = CNT_W'(rem_shift - {1'b0, snap_cnt_q});

    always_ff @(posedge img_720_clk_i) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snap_sum_q   <= '0;
            snap_cnt_q   <= '0;
            snap_min_q   <= '0;
            snap_max_q   <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            iter_q       <= '0;
            busy_q       <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_sum_q   <= '0;
            stat_cnt_q   <= '0;
            stat_min_q   <= '0;
            stat_max_q   <= '0;
            stat_mean_q  <= '0;
        end else begin
            stat_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        snap_sum_q <= run_sum_q;
                        snap_cnt_q <= run_cnt_q;
                        snap_min_q <= run_min_q;
                        snap_max_q <= run_max_q;
                        quo_q      <= run_sum_q;
                        rem_q      <= '0;
                        iter_q     <= '0;
                        if (run_cnt_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_DIV: begin
                    rem_q  <= div_ge ? rem_sub : rem_shift[CNT_W-1:0];
                    quo_q  <= {quo_q[SUM_W-2:0], div_ge};
                    iter_q <= iter_q + IW'(1);
                    if (iter_q == ITER_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    stat_valid_q <= 1'b1;
                    if (snap_cnt_q == '0) begin
                        stat_sum_q  <= '0;
                        stat_cnt_q  <= '0;
                        stat_min_q  <= '0;
                        stat_max_q  <= '0;
                        stat_mean_q <= '0;
                    end else begin
                        stat_sum_q  <= snap_sum_q;
                        stat_cnt_q  <= snap_cnt_q;
                        stat_min_q  <= snap_min_q;
                        stat_max_q  <= snap_max_q;
                        stat_mean_q <= (|quo_q[SUM_W-1:8]) ? 8'hFF : quo_q[7:0];
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stat_valid = stat_valid_q;
    assign stat_sum   = stat_sum_q;
    assign stat_cnt   = stat_cnt_q;
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_mean  = stat_mean_q;
    assign busy       = busy_q;

endmodule
